// File: rtl/fe_capture_ctrl_pkg.sv
// Shared definitions for the front-end capture path: command encodings,
// timestamp widths and the capture-word field layout used by the FIFO packer.
package fe_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        FE_FIFO_CMD_DATA = 2'b00,
        FE_FIFO_CMD_STAT = 2'b01,
        FE_FIFO_CMD_TIME = 2'b10
    } fe_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_DONE
    } fe_state_e;

    localparam int FE_TS_SHORT_WIDTH = 3;
    localparam int FE_TS_FULL_WIDTH  = 16;

    localparam int FE_FIFO_DATA_START = 0;
    localparam int FE_FIFO_DATA_LEN   = 8;
    localparam int FE_FIFO_STAT_START = FE_FIFO_DATA_START + FE_FIFO_DATA_LEN;
    localparam int FE_FIFO_STAT_LEN   = 5;
    localparam int FE_FIFO_TIME_START = FE_FIFO_STAT_START + FE_FIFO_STAT_LEN;
    localparam int FE_FIFO_TIME_LEN   = FE_TS_SHORT_WIDTH;
    localparam int FE_FIFO_CMD_START  = FE_FIFO_TIME_START + FE_FIFO_TIME_LEN;
    localparam int FE_FIFO_CMD_LEN    = 2;
    localparam int FE_FIFO_WORD_WIDTH = FE_FIFO_CMD_START + FE_FIFO_CMD_LEN;

    // Packs a DATA/STAT capture word (short timestamp) into the FIFO layout.
    function automatic logic [FE_FIFO_WORD_WIDTH-1:0] fe_pack_word(
        input fe_cmd_e                      cmd,
        input logic [FE_FIFO_TIME_LEN-1:0]  ts,
        input logic [FE_FIFO_STAT_LEN-1:0]  stat,
        input logic [FE_FIFO_DATA_LEN-1:0]  data
    );
        logic [FE_FIFO_WORD_WIDTH-1:0] word;
        word = '0;
        word[FE_FIFO_DATA_START +: FE_FIFO_DATA_LEN] = data;
        word[FE_FIFO_STAT_START +: FE_FIFO_STAT_LEN] = stat;
        word[FE_FIFO_TIME_START +: FE_FIFO_TIME_LEN] = ts;
        word[FE_FIFO_CMD_START  +: FE_FIFO_CMD_LEN]  = cmd;
        return word;
    endfunction

endpackage

// File: rtl/fe_capture_ctrl_event_queue.sv
// Two-entry event queue between event detection and the capture-word emitter.
module fe_event_queue #(
    parameter int pWIDTH = 30
) (
    input  logic              fe_clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [pWIDTH-1:0] wdata_i,
    input  logic              pop_i,
    output logic [pWIDTH-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [pWIDTH-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A full queue still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign count_d = (push_ok && !pop_ok) ? count_q + 2'd1 :
                     (pop_ok && !push_ok) ? count_q - 2'd1 : count_q;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would race between processes.
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            // NOTE: the storage is only two entries, so it is cleared with the pointers; a deep RAM would be left unreset.
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fe_capture_ctrl.sv
// Front-end capture controller: arm/trigger FSM, delta timestamping and the
// DATA/STAT/TIME capture-word emitter feeding the register/FIFO block.
module fe_capture_ctrl
    import fe_capture_ctrl_pkg::*;
#(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pSTAT_WIDTH            = 5
) (
    input  logic                             fe_clk,
    input  logic                             reset_n,
    input  logic                             I_arm,
    input  logic                             I_timestamps_disable,
    input  logic [15:0]                      I_capture_len,
    input  logic                             I_match,
    input  logic [7:0]                       I_data,
    input  logic                             I_data_valid,
    input  logic [pSTAT_WIDTH-1:0]           I_stat,
    input  logic                             I_fifo_full,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fe_capture_time,
    output logic [7:0]                       O_fe_capture_data,
    output logic [pSTAT_WIDTH-1:0]           O_fe_capture_stat,
    output logic [1:0]                       O_fe_capture_cmd,
    output logic                             O_fe_capture_data_wr,
    output logic                             O_capturing,
    output logic                             O_done,
    output logic                             O_overflow
);

    localparam int TSW = pTIMESTAMP_FULL_WIDTH;
    localparam int QW  = 1 + 8 + pSTAT_WIDTH + TSW;
    localparam logic [TSW-1:0] SHORT_MAX = TSW'((1 << pTIMESTAMP_SHORT_WIDTH) - 1);

    fe_state_e            state_q, state_d;
    logic                 arm_s1_q, arm_s2_q, arm_prev_q;
    logic                 tsd_s1_q, tsd_s2_q;
    logic [pSTAT_WIDTH-1:0] stat_last_q;
    logic [TSW-1:0]       delta_q, delta_d;
    logic [15:0]          count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 time_sent_q, time_sent_d;

    logic                 arm_rise, in_capture, accept, stat_chg;
    logic [TSW-1:0]       delta_ev;
    logic                 q_push, q_pop, q_flush, q_full, q_empty;
    logic [QW-1:0]        q_wdata, q_rdata;
    logic                 head_is_stat;
    logic [7:0]           head_data;
    logic [pSTAT_WIDTH-1:0] head_stat;
    logic [TSW-1:0]       head_delta;
    logic                 emit, need_time, word_wr, event_wr, drop_full;

    assign arm_rise   = arm_s2_q && !arm_prev_q;
    assign in_capture = (state_q == ST_CAPTURE);
    assign stat_chg   = (I_stat != stat_last_q);
    assign accept     = in_capture && (I_data_valid || stat_chg);
    assign delta_ev   = (delta_q == '1) ? delta_q : delta_q + TSW'(1);

    // A byte wins over a simultaneous status change; STAT entries carry data 0.
    assign q_wdata = {!I_data_valid, (I_data_valid ? I_data : 8'h00), I_stat, delta_ev};
    assign q_push  = accept;
    assign q_flush = (state_q == ST_IDLE) || !arm_s2_q;

    fe_event_queue #(.pWIDTH(QW)) u_queue (
        .fe_clk  (fe_clk),
        .reset_n (reset_n),
        .flush_i (q_flush),
        .push_i  (q_push),
        .wdata_i (q_wdata),
        .pop_i   (q_pop),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign head_delta   = q_rdata[TSW-1:0];
    assign head_stat    = q_rdata[TSW +: pSTAT_WIDTH];
    assign head_data    = q_rdata[TSW+pSTAT_WIDTH +: 8];
    assign head_is_stat = q_rdata[QW-1];

    // A long delta costs one extra cycle: TIME word first, then the event word.
    assign emit      = in_capture && !q_empty;
    assign need_time = !tsd_s2_q && !time_sent_q && (head_delta > SHORT_MAX);
    assign word_wr   = emit && !I_fifo_full;
    assign drop_full = emit && I_fifo_full;
    assign event_wr  = word_wr && !need_time;
    assign q_pop     = emit && (!need_time || I_fifo_full);

    always_comb begin
        // NOTE: every output gets a default first so no path through the branches can infer a latch.
        O_fe_capture_data_wr = 1'b0;
        O_fe_capture_cmd     = FE_FIFO_CMD_DATA;
        O_fe_capture_time    = '0;
        O_fe_capture_data    = '0;
        O_fe_capture_stat    = '0;
        if (word_wr) begin
            O_fe_capture_data_wr = 1'b1;
            if (need_time) begin
                O_fe_capture_cmd  = FE_FIFO_CMD_TIME;
                O_fe_capture_time = head_delta;
            end else begin
                O_fe_capture_cmd  = head_is_stat ? FE_FIFO_CMD_STAT : FE_FIFO_CMD_DATA;
                O_fe_capture_data = head_data;
                O_fe_capture_stat = head_stat;
                if (!tsd_s2_q && !time_sent_q)
                    O_fe_capture_time = TSW'(head_delta[pTIMESTAMP_SHORT_WIDTH-1:0]);
            end
        end
    end

    assign O_capturing = in_capture;
    assign O_done      = (state_q == ST_DONE);
    assign O_overflow  = ovf_q;

    always_comb begin
        state_d     = state_q;
        delta_d     = delta_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        time_sent_d = time_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_d = ST_WAIT_TRIG;
                    count_d = '0;
                    delta_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_WAIT_TRIG: begin
                delta_d = '0;
                if (I_match) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                delta_d = accept ? '0 : delta_ev;
                if (event_wr) count_d = count_q + 16'd1;
                if (accept && q_full && !q_pop) ovf_d = 1'b1;
                if (word_wr && need_time) time_sent_d = 1'b1;
                if (q_pop) time_sent_d = 1'b0;
                if (drop_full) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (event_wr && (I_capture_len != 16'd0) &&
                             ((count_q + 16'd1) == I_capture_len)) begin
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase
        if (state_q != ST_CAPTURE) time_sent_d = 1'b0;
        if (!arm_s2_q) state_d = ST_IDLE;
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            arm_s1_q    <= 1'b0;
            arm_s2_q    <= 1'b0;
            arm_prev_q  <= 1'b0;
            tsd_s1_q    <= 1'b0;
            tsd_s2_q    <= 1'b0;
            stat_last_q <= '0;
            delta_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            time_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_s1_q    <= I_arm;
            arm_s2_q    <= arm_s1_q;
            arm_prev_q  <= arm_s2_q;
            tsd_s1_q    <= I_timestamps_disable;
            tsd_s2_q    <= tsd_s1_q;
            stat_last_q <= I_stat;
            delta_q     <= delta_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            time_sent_q <= time_sent_d;
        end
    end

endmodule
